// File: rtl/d8m_pkg.sv
// Shared types and widths for the D8M camera line-capture block.
// FSM encoding plus the line/column counter and frame counter widths.
package d8m_pkg;

  localparam int CNT_W  = 12;
  localparam int FCNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_FS = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DRAIN   = 2'd3
  } cap_state_t;

endpackage

// File: rtl/d8m_line_capture_if.sv
// Bundle of the camera-side sync/data pins and the captured-pixel stream.
// The master drives the sensor side; the slave is the capture block.
interface d8m_line_capture_if #(
  parameter int DATA_W = 10
);
  import d8m_pkg::*;

  logic              enable;
  logic              vsync;
  logic              href;
  logic [DATA_W-1:0] data;

  logic              dval;
  logic [DATA_W-1:0] pix;
  logic [CNT_W-1:0]  x_cnt;
  logic [CNT_W-1:0]  y_cnt;
  logic              frame_start;
  logic              frame_done;
  logic [FCNT_W-1:0] frame_cnt;
  logic              geom_err;

  modport master (
    output enable, vsync, href, data,
    input  dval, pix, x_cnt, y_cnt, frame_start, frame_done, frame_cnt, geom_err
  );

  modport slave (
    input  enable, vsync, href, data,
    output dval, pix, x_cnt, y_cnt, frame_start, frame_done, frame_cnt, geom_err
  );

endinterface

// File: rtl/d8m_edge_det.sv
// Rise/fall pulse detector: holds the previous sample (r2) of an already
// registered signal (r1) and flags transitions between the two.
module d8m_edge_det (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev_p2;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_prev_p2 <= 1'b0;
    else         r_prev_p2 <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev_p2;
  assign o_fall = ~i_sig & r_prev_p2;

endmodule

// File: rtl/d8m_line_capture.sv
// D8M camera line capture: frame-aligned pixel capture with X/Y indexing,
// frame counting and sticky line/frame geometry checking.
module d8m_line_capture
  import d8m_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iENABLE,
  input  logic              iVSYNC,
  input  logic              iHREF,
  input  logic [DATA_W-1:0] iDATA,
  output logic              oDVAL,
  output logic [DATA_W-1:0] oDATA,
  output logic [CNT_W-1:0]  oX_CNT,
  output logic [CNT_W-1:0]  oY_CNT,
  output logic              oFRAME_START,
  output logic              oFRAME_DONE,
  output logic [FCNT_W-1:0] oFRAME_CNT,
  output logic              oGEOM_ERR
);

  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic              r_vsync_p1;
  logic              r_href_p1;
  logic [DATA_W-1:0] r_data_p1;

  logic              w_vs_rise, w_vs_fall;
  logic              w_hs_rise, w_hs_fall;

  cap_state_t        r_state, w_state_nxt;
  logic              w_fs, w_fd;

  logic              w_cap, w_pix, w_line_end, w_trunc;
  logic              w_line_bad, w_frame_bad;
  logic [CNT_W-1:0]  w_x_cur, w_y_end;

  logic              r_dval_p2;
  logic [DATA_W-1:0] r_data_p2;
  logic [CNT_W-1:0]  r_xout_p2;
  logic [CNT_W-1:0]  r_x;
  logic [CNT_W-1:0]  r_y;
  logic              r_fs_p2, r_fd_p2;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic              r_err;

  // Stage p1: sensor pins registered once before any use
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_vsync_p1 <= 1'b0;
      r_href_p1  <= 1'b0;
      r_data_p1  <= '0;
    end else begin
      r_vsync_p1 <= iVSYNC;
      r_href_p1  <= iHREF;
      r_data_p1  <= iDATA;
    end
  end

  d8m_edge_det u_vs_edge (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .i_sig  (r_vsync_p1),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  d8m_edge_det u_hs_edge (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .i_sig  (r_href_p1),
    .o_rise (w_hs_rise),
    .o_fall (w_hs_fall)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fs        = 1'b0;
    w_fd        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (iENABLE) w_state_nxt = ST_WAIT_FS;
      end
      ST_WAIT_FS: begin
        if (!iENABLE) begin
          w_state_nxt = ST_IDLE;
        end else if (w_vs_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_fs        = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_vs_rise) begin
          w_fd        = 1'b1;
          w_state_nxt = iENABLE ? ST_WAIT_FS : ST_IDLE;
        end else if (!iENABLE) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_vs_rise) begin
          w_fd        = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (iENABLE) begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A VSYNC rise while HREF is still high cuts the line: that pixel is
  // dropped, but the partial line still counts toward the line total.
  always_comb begin
    w_cap       = (r_state == ST_ACTIVE) || (r_state == ST_DRAIN);
    w_pix       = w_cap & r_href_p1 & ~w_vs_rise;
    w_x_cur     = w_hs_rise ? '0 : r_x;
    w_trunc     = w_cap & w_vs_rise & r_href_p1;
    w_line_end  = w_cap & (w_hs_fall | w_trunc);
    w_line_bad  = w_line_end & ((r_x != H_ACT_C) | w_trunc);
    w_y_end     = w_line_end ? sat_inc(r_y) : r_y;
    w_frame_bad = w_fd & (w_y_end != V_ACT_C);
  end

  // Stage p2: captured pixel, indices and frame bookkeeping
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_dval_p2   <= 1'b0;
      r_data_p2   <= '0;
      r_xout_p2   <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_fs_p2     <= 1'b0;
      r_fd_p2     <= 1'b0;
      r_frame_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_dval_p2 <= w_pix;
      r_fs_p2   <= w_fs;
      r_fd_p2   <= w_fd;

      if (w_pix) begin
        r_data_p2 <= r_data_p1;
        r_xout_p2 <= w_x_cur;
        r_x       <= sat_inc(w_x_cur);
      end

      if (w_fs) begin
        r_x       <= '0;
        r_y       <= '0;
        r_xout_p2 <= '0;
      end else if (w_line_end) begin
        r_x       <= '0;
        r_xout_p2 <= '0;
        r_y       <= sat_inc(r_y);
      end

      if (w_fd) r_frame_cnt <= r_frame_cnt + 1'b1;

      if (w_fs)                          r_err <= 1'b0;
      else if (w_line_bad | w_frame_bad) r_err <= 1'b1;
    end
  end

  assign oDVAL        = r_dval_p2;
  assign oDATA        = r_data_p2;
  assign oX_CNT       = r_xout_p2;
  assign oY_CNT       = r_y;
  assign oFRAME_START = r_fs_p2;
  assign oFRAME_DONE  = r_fd_p2;
  assign oFRAME_CNT   = r_frame_cnt;
  assign oGEOM_ERR    = r_err;

endmodule

// File: tb/tb_d8m_line_capture.sv
// Scoreboard bench for d8m_line_capture on a reduced 8x4 frame geometry.
// Stimulus pushes expected pixels; a negedge monitor pops and compares.
module tb_d8m_line_capture;
  import d8m_pkg::*;

  localparam int DW = 10;
  localparam int H  = 8;
  localparam int V  = 4;

  typedef struct {
    logic [DW-1:0]    d;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  int   fs_cnt = 0;
  int   fd_cnt = 0;
  int   last_x = -1;
  int   last_y = -1;
  int   pre_close_cnt = 0;
  exp_t q[$];

  d8m_line_capture_if #(.DATA_W(DW)) cam ();

  d8m_line_capture #(.DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .iCLK         (clk),
    .iRST_N       (rst_n),
    .iENABLE      (cam.enable),
    .iVSYNC       (cam.vsync),
    .iHREF        (cam.href),
    .iDATA        (cam.data),
    .oDVAL        (cam.dval),
    .oDATA        (cam.pix),
    .oX_CNT       (cam.x_cnt),
    .oY_CNT       (cam.y_cnt),
    .oFRAME_START (cam.frame_start),
    .oFRAME_DONE  (cam.frame_done),
    .oFRAME_CNT   (cam.frame_cnt),
    .oGEOM_ERR    (cam.geom_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] pixv(input int f, input int y, input int x);
    return DW'((f * 97 + y * 13 + x * 3) & 1023);
  endfunction

  // evt: 0 none, 1 enable on, 2 enable off, 3 enable off/on inside line, 4 reset
  task automatic frame(input int f, input bit exp_cap, input int short_line,
                       input int trunc_line, input int trunc_x,
                       input int evt, input int evt_line);
    bit cap;
    int n;
    exp_t e;
    cap = exp_cap;
    cam.vsync = 1'b0;
    repeat (3) tick();
    for (int y = 0; y < V; y++) begin
      if (y == evt_line) begin
        if (evt == 1) cam.enable = 1'b1;
        if (evt == 2) cam.enable = 1'b0;
        if (evt == 4) begin
          rst_n = 1'b0;
          #2;
          chk("reset_async_outputs",
              {cam.dval, cam.pix, cam.x_cnt, cam.y_cnt, cam.frame_start,
               cam.frame_done, cam.geom_err}, 32'd0);
          chk("reset_async_frame_cnt", {16'd0, cam.frame_cnt}, 32'd0);
          q.delete();
          tick();
          rst_n = 1'b1;
          cap = 1'b0;
        end
      end
      if (y == short_line) chk("geom_err_before_short", {31'd0, cam.geom_err}, 32'd0);
      n = (y == short_line) ? H - 1 : H;
      for (int x = 0; x < n; x++) begin
        if (y == trunc_line && x == trunc_x) begin
          cam.vsync = 1'b1;
          cam.href  = 1'b1;
          cam.data  = pixv(f, y, x);
          tick();
          cam.href = 1'b0;
          repeat (4) tick();
          return;
        end
        if (evt == 3 && y == evt_line && x == 2) cam.enable = 1'b0;
        if (evt == 3 && y == evt_line && x == 5) cam.enable = 1'b1;
        cam.href = 1'b1;
        cam.data = pixv(f, y, x);
        if (cap) begin
          e.d = pixv(f, y, x);
          e.x = CNT_W'(x);
          e.y = CNT_W'(y);
          e.cyc = cyc + 2;
          q.push_back(e);
        end
        tick();
      end
      cam.href = 1'b0;
      repeat (3) tick();
      if (y == short_line) chk("geom_err_at_short_fall", {31'd0, cam.geom_err}, 32'd1);
    end
    pre_close_cnt = int'(cam.frame_cnt);
    cam.vsync = 1'b1;
    repeat (4) tick();
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (cam.frame_start) fs_cnt++;
      if (cam.frame_done)  fd_cnt++;
      if (cam.dval) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_dval actual=x%0d,y%0d,d%0d required=no pixel",
                   cam.x_cnt, cam.y_cnt, cam.pix);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (cam.pix !== e.d || cam.x_cnt !== e.x || cam.y_cnt !== e.y || cyc != e.cyc) begin
            failures++;
            $display("FAIL pixel actual=d%0d x%0d y%0d cyc%0d required=d%0d x%0d y%0d cyc%0d",
                     cam.pix, cam.x_cnt, cam.y_cnt, cyc, e.d, e.x, e.y, e.cyc);
          end
        end
        pops++;
        last_x = int'(cam.x_cnt);
        last_y = int'(cam.y_cnt);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    cam.enable = 1'b0;
    cam.vsync  = 1'b1;
    cam.href   = 1'b0;
    cam.data   = '0;
    repeat (3) tick();
    chk("reset_outputs",
        {cam.dval, cam.pix, cam.x_cnt, cam.y_cnt, cam.frame_start,
         cam.frame_done, cam.geom_err}, 32'd0);
    chk("reset_frame_cnt", {16'd0, cam.frame_cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Enable raised mid-frame: nothing until the next VSYNC fall
    frame(0, 1'b0, -1, -1, -1, 1, 1);
    chk("no_start_partial_frame", fs_cnt, 0);
    chk("no_pixels_partial_frame", pops, 0);

    frame(1, 1'b1, -1, -1, -1, 0, -1);
    chk("first_frame_start", fs_cnt, 1);
    frame(2, 1'b1, -1, -1, -1, 0, -1);
    frame(3, 1'b1, -1, -1, -1, 0, -1);
    chk("three_frames_cnt", {16'd0, cam.frame_cnt}, 32'd3);
    chk("three_frames_err", {31'd0, cam.geom_err}, 32'd0);
    chk("three_frames_pixels", pops, 3 * H * V);
    chk("last_pixel_x", last_x, H - 1);
    chk("last_pixel_y", last_y, V - 1);

    // Short line sets the sticky error, cleared by the next frame start
    frame(4, 1'b1, 1, -1, -1, 0, -1);
    chk("short_err_held", {31'd0, cam.geom_err}, 32'd1);
    frame(5, 1'b1, -1, -1, -1, 0, -1);
    chk("err_cleared_next_frame", {31'd0, cam.geom_err}, 32'd0);
    chk("frame_cnt_5", {16'd0, cam.frame_cnt}, 32'd5);

    // VSYNC rise mid-line truncates the frame
    frame(6, 1'b1, -1, 2, 3, 0, -1);
    chk("trunc_err", {31'd0, cam.geom_err}, 32'd1);
    chk("trunc_frame_done", fd_cnt, 6);
    chk("trunc_frame_cnt", {16'd0, cam.frame_cnt}, 32'd6);

    // Enable dropped and restored inside a line: no pixel lost
    frame(7, 1'b1, -1, -1, -1, 3, 1);
    chk("toggle_err", {31'd0, cam.geom_err}, 32'd0);
    chk("toggle_frame_cnt", {16'd0, cam.frame_cnt}, 32'd7);

    // Enable dropped at line 2: frame drains, then idle
    frame(8, 1'b1, -1, -1, -1, 2, 2);
    chk("drain_frame_cnt", {16'd0, cam.frame_cnt}, 32'd8);
    frame(9, 1'b0, -1, -1, -1, 0, -1);
    chk("idle_no_start", fs_cnt, 8);
    chk("idle_frame_cnt", {16'd0, cam.frame_cnt}, 32'd8);

    // Reset in the middle of a frame
    cam.enable = 1'b1;
    repeat (2) tick();
    frame(10, 1'b1, -1, -1, -1, 4, 2);
    chk("after_reset_frame_cnt", {16'd0, cam.frame_cnt}, 32'd0);
    frame(11, 1'b1, -1, -1, -1, 0, -1);
    chk("cnt_before_complete", pre_close_cnt, 0);
    chk("cnt_after_complete", {16'd0, cam.frame_cnt}, 32'd1);

    repeat (5) tick();
    chk("queue_drained", q.size(), 0);
    chk("total_pixels", pops, 290);
    chk("total_frame_start", fs_cnt, 10);
    chk("total_frame_done", fd_cnt, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
